// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//   Wishbone-programmed sequencer for the user-area up-counter. Software sets a
//   start value (LOAD) and a compare value (CMP), then writes START. The block
//   pulses the counter's load strobe, enables counting until count_i == CMP,
//   records MATCH, optionally reloads (PERIODIC), and raises a level interrupt.
//
//   Optional feature macro: COUNTER_SEQ_PRESCALE_EN
//     When defined, adds an 8-bit PRESCALE register at 0x14 and a divider so
//     the counter increments once every PRESCALE+1 RUN cycles.
//
//   Register map (wbs_adr_i[7:0], decode hit when adr[31:8] == ADDR_BASE[31:8])
//     0x00 CTRL    [0] START (W1, self-clear)  [1] STOP (W1, self-clear)
//                  [2] PERIODIC                [3] IRQ_EN
//     0x04 LOAD    rw, byte-strobed
//     0x08 CMP     rw, byte-strobed
//     0x0C STATUS  [0] BUSY ro   [1] MATCH sticky, W1C
//     0x10 COUNT   ro, current count_i
//     0x14 PRESCALE rw [7:0] (only with COUNTER_SEQ_PRESCALE_EN)
//
//   Ports
//     wb_clk_i, wb_rst_i          clock, async active-high reset
//     wbs_*                       Wishbone slave (registered one-cycle ack)
//     count_i                     counter value observed from the datapath
//     cnt_load_o/cnt_load_val_o   one-cycle load strobe and its value
//     cnt_en_o                    counter increment enable
//     irq_o                       level interrupt = MATCH & IRQ_EN
//
//   FSM states
//     state   | meaning
//     ST_IDLE | counter halted, waiting for START
//     ST_LOAD | one cycle: counter loads LOAD value
//     ST_RUN  | counter increments until count_i == CMP
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int          BITS      = 16,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    output logic            cnt_load_o,
    output logic [BITS-1:0] cnt_load_val_o,
    output logic            cnt_en_o,
    output logic            irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            ack_q;
    logic [31:0]     dat_q;
    logic [BITS-1:0] load_reg;
    logic [BITS-1:0] cmp_reg;
    logic            periodic;
    logic            irq_en;
    logic            match_flag;

    logic [7:0]      offset;
    logic            hit;
    logic            acc;
    logic            wr;
    logic            rd;
    logic [31:0]     byte_mask;
    logic [BITS-1:0] load_merged;
    logic [BITS-1:0] cmp_merged;
    logic            wr_ctrl;
    logic            wr_load;
    logic            wr_cmp;
    logic            wr_status;
    logic            start_w;
    logic            stop_w;
    logic            match_clr;
    logic            match;
    logic            busy;
    logic            tick;
    logic [31:0]     rdata;

    // Only the first cycle of a request is accepted; the registered ack then
    // blocks re-acceptance, so back-to-back requests complete every 2 cycles.
    assign offset = wbs_adr_i[7:0];
    assign hit    = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign acc    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr     = acc & wbs_we_i;
    assign rd     = acc & ~wbs_we_i;

    assign byte_mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                          {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign load_merged = BITS'((32'(load_reg) & ~byte_mask) | (wbs_dat_i & byte_mask));
    assign cmp_merged  = BITS'((32'(cmp_reg)  & ~byte_mask) | (wbs_dat_i & byte_mask));

    assign wr_ctrl   = wr & (offset == 8'h00) & wbs_sel_i[0];
    assign wr_load   = wr & (offset == 8'h04);
    assign wr_cmp    = wr & (offset == 8'h08);
    assign wr_status = wr & (offset == 8'h0C) & wbs_sel_i[0];
    assign start_w   = wr_ctrl & wbs_dat_i[0];
    assign stop_w    = wr_ctrl & wbs_dat_i[1];
    assign match_clr = wr_status & wbs_dat_i[1];

    assign match = (state == ST_RUN) && (count_i == cmp_reg);
    assign busy  = (state != ST_IDLE);

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [7:0] prescale;
    logic [7:0] div;
    logic       wr_pre;

    assign wr_pre = wr & (offset == 8'h14) & wbs_sel_i[0];
    assign tick   = (div == prescale);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prescale <= 8'd0;
            div      <= 8'd0;
        end else begin
            if (wr_pre)
                prescale <= wbs_dat_i[7:0];
            if (state_nxt == ST_LOAD)
                div <= 8'd0;
            else if (state == ST_RUN)
                div <= tick ? 8'd0 : div + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // START/STOP writes override the natural sequence; STOP is applied last
    // so it wins when both are written together or coincide with a match.
    always_comb begin
        state_nxt      = state;
        cnt_load_o     = 1'b0;
        cnt_load_val_o = '0;
        cnt_en_o       = 1'b0;
        case (state)
            ST_LOAD: begin
                cnt_load_o     = 1'b1;
                cnt_load_val_o = load_reg;
                state_nxt      = ST_RUN;
            end
            ST_RUN: begin
                cnt_en_o = ~match & tick;
                if (match)
                    state_nxt = periodic ? ST_LOAD : ST_IDLE;
            end
            default: ;
        endcase
        if (start_w)
            state_nxt = ST_LOAD;
        if (stop_w)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            8'h00: rdata[3:2] = {irq_en, periodic};
            8'h04: rdata      = 32'(load_reg);
            8'h08: rdata      = 32'(cmp_reg);
            8'h0C: rdata[1:0] = {match_flag, busy};
            8'h10: rdata      = 32'(count_i);
`ifdef COUNTER_SEQ_PRESCALE_EN
            8'h14: rdata[7:0] = prescale;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            load_reg   <= '0;
            cmp_reg    <= '0;
            periodic   <= 1'b0;
            irq_en     <= 1'b0;
            match_flag <= 1'b0;
        end else begin
            ack_q <= acc;
            dat_q <= rd ? rdata : 32'd0;
            if (wr_ctrl) begin
                periodic <= wbs_dat_i[2];
                irq_en   <= wbs_dat_i[3];
            end
            if (wr_load)
                load_reg <= load_merged;
            if (wr_cmp)
                cmp_reg <= cmp_merged;
            // a match in the same cycle as the W1C keeps the flag set
            if (match)
                match_flag <= 1'b1;
            else if (match_clr)
                match_flag <= 1'b0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = match_flag & irq_en;

endmodule
